// File: rtl/debug_access_sequencer_pkg.sv
// ============================================================================
// Module  : debug_seq_pkg
// Brief   : Op codes, FSM state type and op-decode helpers for the sequencer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package debug_seq_pkg;

  localparam logic [2:0] OP_RDEXT   = 3'b001;
  localparam logic [2:0] OP_RDINSTR = 3'b010;
  localparam logic [2:0] OP_WREXT   = 3'b011;
  localparam logic [2:0] OP_WRINSTR = 3'b100;
  localparam logic [2:0] OP_RDPC    = 3'b101;
  localparam logic [2:0] MODE_UP    = 3'b000;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HALT    = 3'd1,
    ST_ISSUE   = 3'd2,
    ST_WAIT    = 3'd3,
    ST_RELEASE = 3'd4,
    ST_RESP    = 3'd5
  } state_t;

  function automatic logic is_legal_op(input logic [2:0] op);
    return (op == OP_RDEXT) || (op == OP_RDINSTR) || (op == OP_WREXT) ||
           (op == OP_WRINSTR) || (op == OP_RDPC);
  endfunction

  function automatic logic is_read_op(input logic [2:0] op);
    return (op == OP_RDEXT) || (op == OP_RDINSTR) || (op == OP_RDPC);
  endfunction

  // Instruction-memory ops complete on doneInstr; everything else on doneExt.
  function automatic logic uses_instr_done(input logic [2:0] op);
    return (op == OP_RDINSTR) || (op == OP_WRINSTR);
  endfunction

endpackage

`default_nettype wire

// File: rtl/debug_access_sequencer_if.sv
// ============================================================================
// Module  : debug_access_sequencer_if
// Brief   : Host command/response, core halt and interconnect signal bundle.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface debug_access_sequencer_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();

  logic              cmdValid;
  logic              cmdReady;
  logic [2:0]        cmdOp;
  logic [ADDR_W-1:0] cmdAddr;
  logic [DATA_W-1:0] cmdWData;
  logic              rspValid;
  logic              rspReady;
  logic [DATA_W-1:0] rspData;
  logic              rspErr;
  logic              haltReq;
  logic              haltAck;
  logic [2:0]        mode;
  logic [ADDR_W-1:0] debugAddress;
  logic [DATA_W-1:0] DEBUGWrite;
  logic [DATA_W-1:0] dataReadDebug;
  logic              doneExt;
  logic              doneInstr;
  logic              busy;

  modport slave (
    input  cmdValid, cmdOp, cmdAddr, cmdWData, rspReady, haltAck,
           dataReadDebug, doneExt, doneInstr,
    output cmdReady, rspValid, rspData, rspErr, haltReq, mode,
           debugAddress, DEBUGWrite, busy
  );

  modport master (
    output cmdValid, cmdOp, cmdAddr, cmdWData, rspReady, haltAck,
           dataReadDebug, doneExt, doneInstr,
    input  cmdReady, rspValid, rspData, rspErr, haltReq, mode,
           debugAddress, DEBUGWrite, busy
  );

endinterface

`default_nettype wire

// File: rtl/debug_access_sequencer_timeout_ctr.sv
// ============================================================================
// Module  : debug_timeout_ctr
// Brief   : Counts wait cycles; expired is high in the TIMEOUT_CYCLES-th one.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module debug_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_disabled
      logic unused_inputs;
      assign unused_inputs = &{1'b0, clk, reset, clear, enable};
      assign expired = 1'b0;
    end else begin : g_enabled
      localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
      localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

      logic [CNT_W-1:0] count;

      // Counter holds at LAST so it can never wrap back to a non-expired value.
      always_ff @(posedge clk) begin
        if (reset || clear) begin
          count <= '0;
        end else if (enable && !expired) begin
          count <= count + 1'b1;
        end
      end

      assign expired = (count == LAST);
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/debug_access_sequencer.sv
// ============================================================================
// Module  : debug_access_sequencer
// Brief   : Halts the core and sequences one debug access onto the interconnect.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module debug_access_sequencer
  import debug_seq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  debug_access_sequencer_if.slave  bus
);

  state_t            state;
  logic [2:0]        cur_op;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_wdata;

  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;
  logic              halt_req;
  logic [2:0]        mode_q;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;

  logic              done_seen;
  logic              tmo_expired;

  assign done_seen = uses_instr_done(cur_op) ? bus.doneInstr : bus.doneExt;

  debug_timeout_ctr #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (state == ST_ISSUE),
    .enable  (state == ST_WAIT),
    .expired (tmo_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      cur_op    <= MODE_UP;
      cur_addr  <= '0;
      cur_wdata <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      halt_req  <= 1'b0;
      mode_q    <= MODE_UP;
      dbg_addr  <= '0;
      dbg_wdata <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.cmdValid) begin
            cur_op    <= bus.cmdOp;
            cur_addr  <= bus.cmdAddr;
            cur_wdata <= bus.cmdWData;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            if (is_legal_op(bus.cmdOp)) begin
              halt_req <= 1'b1;
              state    <= ST_HALT;
            end else begin
              // Illegal ops never touch the core or the interconnect.
              rsp_err   <= 1'b1;
              rsp_valid <= 1'b1;
              state     <= ST_RESP;
            end
          end
        end

        ST_HALT: begin
          if (bus.haltAck) begin
            mode_q    <= cur_op;
            dbg_addr  <= cur_addr;
            dbg_wdata <= cur_wdata;
            state     <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          if (cur_op == OP_RDPC) begin
            mode_q <= MODE_UP;
            state  <= ST_RELEASE;
          end else begin
            state <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (done_seen) begin
            rsp_data <= is_read_op(cur_op) ? bus.dataReadDebug : '0;
            mode_q   <= MODE_UP;
            state    <= ST_RELEASE;
          end else if (tmo_expired) begin
            rsp_err  <= 1'b1;
            rsp_data <= '0;
            mode_q   <= MODE_UP;
            state    <= ST_RELEASE;
          end
        end

        ST_RELEASE: begin
          // The PC is presented by the interconnect once mode is back to uP.
          if (cur_op == OP_RDPC) begin
            rsp_data <= bus.dataReadDebug;
          end
          rsp_valid <= 1'b1;
          state     <= ST_RESP;
        end

        ST_RESP: begin
          if (bus.rspReady) begin
            rsp_valid <= 1'b0;
            halt_req  <= 1'b0;
            state     <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.cmdReady     = (state == ST_IDLE);
  assign bus.busy         = (state != ST_IDLE);
  assign bus.rspValid     = rsp_valid;
  assign bus.rspData      = rsp_data;
  assign bus.rspErr       = rsp_err;
  assign bus.haltReq      = halt_req;
  assign bus.mode         = mode_q;
  assign bus.debugAddress = dbg_addr;
  assign bus.DEBUGWrite   = dbg_wdata;

endmodule

`default_nettype wire

// File: tb/tb_debug_access_sequencer.sv
// ============================================================================
// Module  : tb_debug_access_sequencer
// Brief   : Randomized bench for debug_access_sequencer against a timing model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_debug_access_sequencer;

  localparam int T = 8;

  logic clk;
  logic reset;
  int   tests;
  int   fails;

  debug_access_sequencer_if #(.ADDR_W(32), .DATA_W(32)) dif ();

  debug_access_sequencer #(
    .TIMEOUT_CYCLES (T),
    .ADDR_W         (32),
    .DATA_W         (32)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One full command: the model derives every per-cycle expectation from
  // the command, halt delay h, done cycle d (1-based WAIT index; 0 = never)
  // and response backpressure rdy.
  task automatic do_cmd(input logic [2:0] op, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rdata,
                        input logic [31:0] pcdata, input int h, input int d,
                        input int rdy, input string tag);
    bit          legal, rdpc, is_rd, use_instr, done_ok, exp_err, in_wait, exp_valid;
    int          w, resp_n, last_n, k;
    logic [31:0] exp_data;
    logic [2:0]  exp_mode;
    logic        watched;
    legal     = (op >= 3'd1) && (op <= 3'd5);
    rdpc      = (op == 3'd5);
    is_rd     = (op == 3'd1) || (op == 3'd2) || (op == 3'd5);
    use_instr = (op == 3'd2) || (op == 3'd4);
    done_ok   = (d >= 1) && (d <= T);
    w         = rdpc ? 0 : (done_ok ? d : T);
    exp_err   = !legal || (!rdpc && !done_ok);
    exp_data  = exp_err ? 32'h0 : (rdpc ? pcdata : (is_rd ? rdata : 32'h0));
    resp_n    = legal ? h + w + 3 : 1;
    last_n    = resp_n + rdy;

    tests++;
    if (dif.cmdReady !== 1'b1) begin
      fails++;
      $display("FAIL %s idle_ready: got %b want 1", tag, dif.cmdReady);
    end
    dif.cmdValid = 1'b1;
    dif.cmdOp    = op;
    dif.cmdAddr  = addr;
    dif.cmdWData = wdata;
    dif.haltAck  = (h == 1);
    dif.doneExt  = 1'b0;
    dif.doneInstr = 1'b0;
    dif.rspReady = 1'($urandom);

    for (int n = 1; n <= last_n; n++) begin
      @(posedge clk); #1;
      if (n == 1) begin
        dif.cmdValid = 1'b0;
        dif.cmdOp    = 3'($urandom);
        dif.cmdAddr  = $urandom;
        dif.cmdWData = $urandom;
      end
      exp_mode  = (legal && n >= h + 1 && n <= h + 1 + w) ? op : 3'b000;
      exp_valid = (n >= resp_n);
      tests++;
      if ({dif.rspValid, dif.cmdReady, dif.busy, dif.haltReq, dif.mode} !==
          {exp_valid, 1'b0, 1'b1, legal, exp_mode}) begin
        fails++;
        $display("FAIL %s ctrl cyc%0d: got v/rdy/busy/halt/mode=%b%b%b%b/%h want %b01%b/%h",
                 tag, n, dif.rspValid, dif.cmdReady, dif.busy, dif.haltReq, dif.mode,
                 exp_valid, legal, exp_mode);
      end
      if (exp_mode != 3'b000) begin
        tests++;
        if ({dif.debugAddress, dif.DEBUGWrite} !== {addr, wdata}) begin
          fails++;
          $display("FAIL %s bus cyc%0d: got addr=%h wr=%h want addr=%h wr=%h",
                   tag, n, dif.debugAddress, dif.DEBUGWrite, addr, wdata);
        end
      end
      if (exp_valid) begin
        tests++;
        if ({dif.rspErr, dif.rspData} !== {exp_err, exp_data}) begin
          fails++;
          $display("FAIL %s rsp cyc%0d: got err=%b data=%h want err=%b data=%h",
                   tag, n, dif.rspErr, dif.rspData, exp_err, exp_data);
        end
      end

      // Inputs for cycle n; stray done pulses and haltAck drops are noise.
      k       = n - (h + 1);
      in_wait = legal && !rdpc && (k >= 1) && (k <= w);
      watched = in_wait ? (k == d) : 1'($urandom);
      if (use_instr) begin
        dif.doneInstr = watched;
        dif.doneExt   = 1'($urandom);
      end else begin
        dif.doneExt   = watched;
        dif.doneInstr = 1'($urandom);
      end
      if (in_wait && k == d)          dif.dataReadDebug = rdata;
      else if (rdpc && n == h + 2)    dif.dataReadDebug = pcdata;
      else                            dif.dataReadDebug = $urandom;
      dif.haltAck  = (n < h) ? 1'b0 : ((n == h) ? 1'b1 : 1'($urandom));
      dif.rspReady = (n >= resp_n) ? (n == last_n) : 1'($urandom);
    end

    @(posedge clk); #1;
    tests++;
    if ({dif.rspValid, dif.cmdReady, dif.busy, dif.haltReq, dif.mode} !== 7'b0100_000) begin
      fails++;
      $display("FAIL %s post_hs: got v/rdy/busy/halt/mode=%b%b%b%b/%h want 0100/0",
               tag, dif.rspValid, dif.cmdReady, dif.busy, dif.haltReq, dif.mode);
    end
    dif.rspReady  = 1'b0;
    dif.doneExt   = 1'b0;
    dif.doneInstr = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    dif.cmdValid = 1'b1;
    dif.cmdOp    = 3'b001;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({dif.cmdReady, dif.rspValid, dif.rspData, dif.rspErr, dif.haltReq, dif.mode,
         dif.debugAddress, dif.DEBUGWrite, dif.busy} !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0,
         3'b000, 32'h0, 32'h0, 1'b0}) begin
      fails++;
      $display("FAIL reset_values: got rdy=%b v=%b d=%h e=%b h=%b m=%h a=%h w=%h b=%b",
               dif.cmdReady, dif.rspValid, dif.rspData, dif.rspErr, dif.haltReq,
               dif.mode, dif.debugAddress, dif.DEBUGWrite, dif.busy);
    end
    dif.cmdValid = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_rd_ext();
    do_cmd(3'b001, 32'h100, $urandom, 32'hDEADBEEF, $urandom, 1, 3, 0, "rd_ext");
  endtask

  task automatic test_wr_instr();
    do_cmd(3'b100, 32'h40, 32'h12345678, $urandom, $urandom, 1, 2, 0, "wr_instr");
  endtask

  task automatic test_rd_pc();
    do_cmd(3'b101, $urandom, $urandom, $urandom, 32'h200, 1, 0, 0, "rd_pc");
  endtask

  task automatic test_timeout();
    do_cmd(3'b001, 32'h80, $urandom, $urandom, $urandom, 1, 0, 2, "timeout");
    do_cmd(3'b010, 32'h84, $urandom, 32'h55AA55AA, $urandom, 2, T, 0, "done_at_limit");
  endtask

  task automatic test_illegal();
    do_cmd(3'b110, $urandom, $urandom, $urandom, $urandom, 1, 1, 0, "illegal_110");
    do_cmd(3'b000, $urandom, $urandom, $urandom, $urandom, 1, 1, 1, "illegal_000");
    do_cmd(3'b111, $urandom, $urandom, $urandom, $urandom, 1, 1, 0, "illegal_111");
  endtask

  task automatic test_backpressure();
    do_cmd(3'b010, 32'h300, $urandom, 32'hCAFEF00D, $urandom, 3, 4, 5, "backpressure");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 40; i++) begin
      do_cmd(3'($urandom), $urandom, $urandom, $urandom, $urandom,
             int'($urandom_range(1, 3)), int'($urandom_range(0, T + 2)),
             int'($urandom_range(0, 3)), "random");
    end
  endtask

  task automatic test_reset_mid_op();
    dif.cmdValid = 1'b1;
    dif.cmdOp    = 3'b011;
    dif.cmdAddr  = 32'h44;
    dif.cmdWData = 32'hA5A5A5A5;
    dif.haltAck  = 1'b1;
    dif.doneExt  = 1'b0;
    @(posedge clk); #1;
    dif.cmdValid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (dif.mode !== 3'b011) begin
      fails++;
      $display("FAIL mid_reset_wait_mode: got %h want 3", dif.mode);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    tests++;
    if ({dif.cmdReady, dif.rspValid, dif.rspData, dif.rspErr, dif.haltReq, dif.mode,
         dif.debugAddress, dif.DEBUGWrite, dif.busy} !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0,
         3'b000, 32'h0, 32'h0, 1'b0}) begin
      fails++;
      $display("FAIL mid_reset_values: got rdy=%b v=%b d=%h e=%b h=%b m=%h a=%h w=%h b=%b",
               dif.cmdReady, dif.rspValid, dif.rspData, dif.rspErr, dif.haltReq,
               dif.mode, dif.debugAddress, dif.DEBUGWrite, dif.busy);
    end
    reset = 1'b0;
    dif.doneExt = 1'b1;
    dif.rspReady = 1'b1;
    for (int n = 0; n < 6; n++) begin
      @(posedge clk); #1;
      tests++;
      if ({dif.rspValid, dif.cmdReady, dif.mode} !== 5'b01_000) begin
        fails++;
        $display("FAIL mid_reset_quiet cyc%0d: got v/rdy/mode=%b%b/%h want 01/0",
                 n, dif.rspValid, dif.cmdReady, dif.mode);
      end
    end
    dif.doneExt  = 1'b0;
    dif.rspReady = 1'b0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    dif.cmdValid      = 1'b0;
    dif.cmdOp         = 3'b000;
    dif.cmdAddr       = '0;
    dif.cmdWData      = '0;
    dif.rspReady      = 1'b0;
    dif.haltAck       = 1'b0;
    dif.dataReadDebug = '0;
    dif.doneExt       = 1'b0;
    dif.doneInstr     = 1'b0;
    test_reset();
    test_rd_ext();
    test_wr_instr();
    test_rd_pc();
    test_timeout();
    test_illegal();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_op();
    test_rd_ext();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
